// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, port ids and
// the in-flight access record carried alongside the SRAM pipeline.
package sram_arb_pkg;

  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // One accepted access travelling towards its data cycle
  typedef struct packed {
    logic                  valid;
    logic                  port;
    logic                  we;
    logic [DEF_DATA_W-1:0] wdata;
  } pipe_entry_t;

endpackage

// File: rtl/sram_pipe_tracker.sv
// Shift register that follows each accepted access from its address cycle
// to its data cycle, so write data and read responses line up with the SRAM.
module sram_pipe_tracker
  import sram_arb_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  pipe_entry_t push_entry,
  output pipe_entry_t wr_entry,
  output pipe_entry_t rsp_entry
);

  pipe_entry_t stage [LATENCY+1];

  // Advance every cycle; reset drops everything still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push_entry;
      for (int i = 1; i <= LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Stage 0 is the address cycle, so the last stage is the SRAM data cycle:
  // writes drive ZD there and reads sample ZD at its closing edge.
  assign wr_entry  = stage[LATENCY];
  assign rsp_entry = stage[LATENCY];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the ZBT SRAM: CPU and RS-232C loader share
// one access per cycle, round-robin on ties, with read data routed back to
// the requester that issued it.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              ldr_pri;
  logic              grant_c;
  logic              grant_l;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  pipe_entry_t       push_entry;
  pipe_entry_t       wr_entry;
  pipe_entry_t       rsp_entry;

  // Grant: a lone requester wins; on a tie ldr_pri picks the loader
  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    if (!reset) begin
      if (c_req && l_req) begin
        grant_l = ldr_pri;
        grant_c = ~ldr_pri;
      end else begin
        grant_c = c_req;
        grant_l = l_req;
      end
    end
  end

  assign accept = grant_c | grant_l;
  assign c_gnt  = grant_c;
  assign l_gnt  = grant_l;

  // Select the accepted request's fields for the address phase and pipeline
  always_comb begin
    push_entry = '0;
    acc_addr   = c_addr;
    if (grant_l) begin
      push_entry.valid = 1'b1;
      push_entry.port  = PORT_LDR;
      push_entry.we    = l_we;
      push_entry.wdata = l_wdata;
      acc_addr         = l_addr;
    end else if (grant_c) begin
      push_entry.valid = 1'b1;
      push_entry.port  = PORT_CPU;
      push_entry.we    = c_we;
      push_entry.wdata = c_wdata;
      acc_addr         = c_addr;
    end
  end

  // Round-robin pointer: after an accept the other port gets the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      ldr_pri <= 1'b1;
    end else if (accept) begin
      ldr_pri <= grant_c;
    end
  end

  // Address phase registers; idle cycles deselect but keep the last address
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else if (accept) begin
      sram_addr <= acc_addr;
      sram_ce_n <= 1'b0;
      sram_we_n <= ~push_entry.we;
    end else begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
    end
  end

  sram_pipe_tracker #(
    .LATENCY (LATENCY)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .push_entry (push_entry),
    .wr_entry   (wr_entry),
    .rsp_entry  (rsp_entry)
  );

  assign sram_oe    = wr_entry.valid & wr_entry.we;
  assign sram_wdata = sram_oe ? wr_entry.wdata : '0;

  // Capture read data at the end of the data cycle and pulse the issuing port
  always_ff @(posedge clk) begin
    if (reset) begin
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      c_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      if (rsp_entry.valid && !rsp_entry.we) begin
        if (rsp_entry.port == PORT_LDR) begin
          l_rvalid <= 1'b1;
          l_rdata  <= sram_rdata;
        end else begin
          c_rvalid <= 1'b1;
          c_rdata  <= sram_rdata;
        end
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external ZBT SRAM between two requesters.
- Requester 0 is the CPU data/instruction memory port. Requester 1 is the RS-232C program loader, which writes received words into SRAM until the 0xffffffff end marker.
- Arbitrates one access per cycle, drives a pipelined SRAM interface with fixed read/write latency, and returns read data to the requester that issued it.
- Sits in top between the CPU/loader and the SRAM pin drivers (ZA, XWA, XE1, ZD tristate).

Parameters:
ADDR_W, 20, word address width (matches ZA)
DATA_W, 32, data width (matches ZD)
LATENCY, 2, SRAM cycles from address cycle to data cycle (ZBT pipelined = 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
c_req  in  1  CPU request
c_we  in  1  CPU write (1) / read (0)
c_addr  in  ADDR_W  CPU word address
c_wdata  in  DATA_W  CPU write data
c_gnt  out  1  CPU request accepted this cycle (combinational)
c_rvalid  out  1  CPU read data valid (one-cycle pulse)
c_rdata  out  DATA_W  CPU read data
l_req  in  1  loader request
l_we  in  1  loader write / read
l_addr  in  ADDR_W  loader word address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader accepted (combinational)
l_rvalid  out  1  loader read data valid
l_rdata  out  DATA_W  loader read data
sram_addr  out  ADDR_W  to ZA
sram_ce_n  out  1  to XE1, active-low chip enable
sram_we_n  out  1  to XWA, active-low write
sram_wdata  out  DATA_W  to ZD output driver
sram_oe  out  1  ZD tristate enable (1 = drive sram_wdata)
sram_rdata  in  DATA_W  from ZD input

Behaviour:
- Reset: all outputs 0 except sram_ce_n=1 and sram_we_n=1. Pipeline tags cleared. Round-robin pointer set so the loader wins the first tie.
- Accept: the arbiter accepts in cycle A a requester with req=1 whose gnt=1. gnt is combinational from req and the pointer.
- Arbitration:
  - Only one req high -> that requester is granted.
  - Both high -> grant the requester not granted most recently; pointer updates on each accept.
  - Neither high -> no gnt.
  - A non-granted requester holds req/addr/we/wdata stable until granted.
- Address phase, cycle A+1 (registered): sram_addr=addr, sram_ce_n=0, sram_we_n=~we. Idle cycles drive ce_n=1, we_n=1, addr held.
- Write data phase: cycle A+1+LATENCY drives sram_wdata=wdata (captured at accept and delayed through the pipeline) with sram_oe=1. Otherwise sram_oe=0.
- Read data: sram_rdata is sampled at the end of cycle A+1+LATENCY. In cycle A+2+LATENCY (A+4 for default LATENCY), the issuing port's rvalid=1 for exactly one cycle and its rdata = sampled value. The other port's rvalid stays 0. rdata holds its last value when rvalid=0.
- Throughput: one access per cycle, fully pipelined. Back-to-back read/write mixes need no turnaround (ZBT). Writes produce no rvalid.
- Tag pipeline: LATENCY+1 deep shift register. Each entry holds {valid, port, we, wdata}; it advances every cycle.
- Ordering: responses per port return in issue order; rvalid pulses from consecutive accepts land on consecutive cycles.
- Reset mid-operation: in-flight entries discarded. No rvalid, no sram_oe after reset asserts. The address phase returns to idle on the next edge.
- Simultaneous accept and response in the same cycle is legal and independent.

Decomposition:
- Package sram_arb_pkg holds:
  - ADDR_W, DATA_W, LATENCY defaults
  - port id constants PORT_CPU=0, PORT_LDR=1
  - pipeline entry struct {valid, port, we, wdata}
- Sub-module sram_pipe_tracker: parameterised shift register of entries. It exposes the write-phase entry and the response-phase entry.
- Arbitration and output registers stay in sram_arbiter.

Test Plan:
- Loader alone writes 0xdeadbeef to addr 0x00010 -> l_gnt in cycle A. Cycle A+1: sram_addr=0x00010, ce_n=0, we_n=0. Cycle A+3: sram_oe=1, sram_wdata=0xdeadbeef. No rvalid on either port.
- CPU reads addr 0x00010 while the fake SRAM returns 0x12345678 -> c_rvalid=1 and c_rdata=0x12345678 exactly at A+4. l_rvalid=0.
- Both request reads every cycle (CPU addr 0x1,0x2; loader 0x100,0x101) -> grants alternate L,C,L,C after reset. The rvalid pulses alternate on consecutive cycles with matching data.
- Interleaved write 0x00020=0xaaaa5555, then read 0x00020 on the next cycle (same port) -> sram_oe high only in the write's data cycle. The read returns 0xaaaa5555 from the fake SRAM.
- Reset asserted one cycle after three reads are accepted -> no rvalid emitted, sram_ce_n=1, sram_we_n=1, sram_oe=0 from the next edge. The first post-reset tie goes to the loader.
- Loader streams 4 words ending with 0xffffffff while the CPU is idle -> 4 consecutive write address cycles with no bubbles. Data phases follow 2 cycles later in order.
